// File: rtl/s_aram_arbiter_if.sv
// s_aram_arbiter_if: requester ports (CPU, DSP, debug) and the ARAM-side
// bus of the ARAM arbiter, bundled for module ports.
interface s_aram_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;

    logic        dsp_req;
    logic        dsp_we;
    logic [15:0] dsp_addr;
    logic [7:0]  dsp_wdata;
    logic        dsp_ack;

    logic        dbg_req;
    logic        dbg_we;
    logic [15:0] dbg_addr;
    logic [7:0]  dbg_wdata;
    logic        dbg_ack;

    logic [7:0]  rdata;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dsp_req, dsp_we, dsp_addr, dsp_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  ram_rdata,
        output cpu_ack, dsp_ack, dbg_ack,
        output rdata, ram_addr, ram_wdata, ram_we
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dsp_req, dsp_we, dsp_addr, dsp_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output ram_rdata,
        input  cpu_ack, dsp_ack, dbg_ack,
        input  rdata, ram_addr, ram_wdata, ram_we
    );
endinterface

// File: rtl/s_aram_arbiter.sv
// s_aram_arbiter: ARAM arbiter, priority DSP > DBG > CPU with CPU anti-starvation.
// Debug port arbitrates only when ARAM_DBG_PORT_EN is defined.
module s_aram_arbiter #(
    parameter int ACC_CYCLES = 2,
    parameter int STARVE_MAX = 8
) (
    input logic             clk,
    input logic             reset_n,
    s_aram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic [1:0] {W_NONE, W_CPU, W_DSP, W_DBG} win_t;

    localparam logic [1:0] CYC_LAST   = 2'(ACC_CYCLES - 1);
    localparam logic [7:0] STARVE_TOP = 8'(STARVE_MAX);

    state_t      state;
    state_t      state_nxt;
    win_t        win;
    win_t        win_nxt;
    win_t        pick;
    logic [1:0]  cyc;
    logic [7:0]  starve;
    logic        lat_we;
    logic [15:0] lat_addr;
    logic [7:0]  lat_wdata;
    logic [7:0]  rdata_q;
    logic        dbg_act;
    logic        cpu_force;
    logic        cpu_win;
    logic        last;
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [7:0]  sel_wdata;

`ifdef ARAM_DBG_PORT_EN
    assign dbg_act     = bus.dbg_req;
    assign bus.dbg_ack = (state == DONE) && (win == W_DBG);
`else
    logic unused_dbg;
    assign unused_dbg  = bus.dbg_req;
    assign dbg_act     = 1'b0;
    assign bus.dbg_ack = 1'b0;
`endif

    assign cpu_force = bus.cpu_req && (starve == STARVE_TOP);
    assign last      = (cyc == CYC_LAST);

    always_comb begin
        pick = W_NONE;
        priority case (1'b1)
            cpu_force:   pick = W_CPU;
            bus.dsp_req: pick = W_DSP;
            dbg_act:     pick = W_DBG;
            bus.cpu_req: pick = W_CPU;
            default:     pick = W_NONE;
        endcase
    end

    always_comb begin
        sel_we    = bus.cpu_we;
        sel_addr  = bus.cpu_addr;
        sel_wdata = bus.cpu_wdata;
        case (pick)
            W_DSP: begin
                sel_we    = bus.dsp_we;
                sel_addr  = bus.dsp_addr;
                sel_wdata = bus.dsp_wdata;
            end
            W_DBG: begin
                sel_we    = bus.dbg_we;
                sel_addr  = bus.dbg_addr;
                sel_wdata = bus.dbg_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        win_nxt   = win;
        unique case (state)
            IDLE: begin
                if (pick != W_NONE) begin
                    state_nxt = ACCESS;
                    win_nxt   = pick;
                end
            end
            ACCESS: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
                win_nxt   = W_NONE;
            end
            default: begin
                state_nxt = IDLE;
                win_nxt   = W_NONE;
            end
        endcase
    end

    // CPU counts as winning both on its grant edge and while its access runs
    assign cpu_win = (state == IDLE) ? (pick == W_CPU) : (win == W_CPU);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            win   <= W_NONE;
            cyc   <= 2'd0;
        end else begin
            state <= state_nxt;
            win   <= win_nxt;
            cyc   <= (state == ACCESS && !last) ? cyc + 2'd1 : 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_we    <= 1'b0;
            lat_addr  <= 16'h0000;
            lat_wdata <= 8'h00;
            rdata_q   <= 8'h00;
            starve    <= 8'h00;
        end else begin
            if (state == IDLE && pick != W_NONE) begin
                lat_we    <= sel_we;
                lat_addr  <= sel_addr;
                lat_wdata <= sel_wdata;
            end
            if (state == ACCESS && last && !lat_we)
                rdata_q <= bus.ram_rdata;
            if (!bus.cpu_req || cpu_win)
                starve <= 8'h00;
            else if (starve != STARVE_TOP)
                starve <= starve + 8'h01;
        end
    end

    assign bus.ram_we    = (state == ACCESS) && lat_we;
    assign bus.ram_addr  = lat_addr;
    assign bus.ram_wdata = lat_wdata;
    assign bus.rdata     = rdata_q;
    assign bus.cpu_ack   = (state == DONE) && (win == W_CPU);
    assign bus.dsp_ack   = (state == DONE) && (win == W_DSP);
endmodule
